// File: rtl/simple_ctl_pkg.sv
// rtl/simple_ctl_pkg.sv - shared sequencer state type and datapath sizing constants
package simple_ctl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      HALT = 2'd3
   } run_state_t;

   localparam int NPHASE_DEF = 5;
   localparam int PC_W_DEF   = 16;

endpackage

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - one-bit rising-edge detector for synchronous button levels
module edge_rise (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_q <= 1'b0;
      else        d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/run_controller.sv
// rtl/run_controller.sv - phase ring and run/step/pause/halt/breakpoint sequencer
module run_controller
   import simple_ctl_pkg::*;
#(
   parameter int NPHASE = NPHASE_DEF,
   parameter int PC_W   = PC_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              exec_lvl,
   input  logic              step_mode,
   input  logic              halt_req,
   input  logic              bp_en,
   input  logic [PC_W-1:0]   bp_addr,
   input  logic [PC_W-1:0]   pc_next,
   output logic [NPHASE-1:0] phase,
   output logic              pc_we,
   output logic              running,
   output logic              halted,
   output logic              bp_hit,
   output logic [CNT_W-1:0]  instr_cnt
);

   run_state_t        state_q, state_d;
   logic [NPHASE-1:0] phase_q, phase_d;
   logic              running_q, running_d;
   logic              halted_q, halted_d;
   logic              bp_hit_q, bp_hit_d;
   logic              pause_q, pause_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              exec_rise;
   logic              boundary;

   edge_rise u_exec_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (exec_lvl),
      .rise  (exec_rise)
   );

   // The ring is all-zero outside RUN/STEP, so the top bit alone marks a boundary.
   assign boundary = phase_q[NPHASE-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
         bp_hit_q  <= 1'b0;
         pause_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         running_q <= running_d;
         halted_q  <= halted_d;
         bp_hit_q  <= bp_hit_d;
         pause_q   <= pause_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      halted_d = halted_q;
      bp_hit_d = bp_hit_q;
      pause_d  = pause_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            phase_d = '0;
            if (exec_rise) begin
               state_d  = step_mode ? STEP : RUN;
               phase_d  = NPHASE'(1);
               bp_hit_d = 1'b0;
            end
         end
         RUN, STEP: begin
            phase_d = {phase_q[NPHASE-2:0], phase_q[NPHASE-1]};
            if (boundary) begin
               cnt_d = cnt_q + CNT_W'(1);
               // Priority order: HLT, pause request, breakpoint, single-step.
               if (halt_req) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
                  phase_d  = '0;
               end else if (state_q == RUN && (pause_q || exec_rise)) begin
                  state_d = IDLE;
                  pause_d = 1'b0;
                  phase_d = '0;
               end else if (bp_en && pc_next == bp_addr) begin
                  state_d  = IDLE;
                  bp_hit_d = 1'b1;
                  phase_d  = '0;
               end else if (state_q == STEP) begin
                  state_d = IDLE;
                  phase_d = '0;
               end
            end else if (state_q == RUN && exec_rise) begin
               pause_d = 1'b1;
            end
         end
         default: begin
            phase_d = '0;
         end
      endcase
      running_d = (state_d == RUN) || (state_d == STEP);
   end

   assign phase     = phase_q;
   assign pc_we     = phase_q[NPHASE-1] & ~halt_req;
   assign running   = running_q;
   assign halted    = halted_q;
   assign bp_hit    = bp_hit_q;
   assign instr_cnt = cnt_q;

endmodule
